// File: rtl/mult_seq_if.sv
// mult_seq_if - request/response and ALU-sharing bus of the multiply sequencer.
//
// Signals:
//   start, mcand[15:0], mplier[15:0]     request side (driven by master)
//   busy, done, result[15:0]             status/result (driven by slave)
//   alu_en, alu_A, alu_B, alu_Op,
//   alu_invA, alu_invB, alu_Cin,
//   alu_lower_two                        ALU operand/control (driven by slave)
//   alu_Out[15:0]                        ALU result (driven by master side)
//
// Modports:
//   slave  - the sequencer (mult_seq)
//   master - the execute stage that issues requests and owns the ALU
interface mult_seq_if;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        alu_en;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [4:0]  alu_Op;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_Cin;
    logic [1:0]  alu_lower_two;
    logic [15:0] alu_Out;

    modport slave (
        input  start, mcand, mplier, alu_Out,
        output busy, done, result,
        output alu_en, alu_A, alu_B, alu_Op, alu_invA, alu_invB, alu_Cin, alu_lower_two
    );

    modport master (
        output start, mcand, mplier, alu_Out,
        input  busy, done, result,
        input  alu_en, alu_A, alu_B, alu_Op, alu_invA, alu_invB, alu_Cin, alu_lower_two
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq - multi-cycle unsigned 16x16 multiply (low 16 bits of product)
// by shift-and-add, borrowing the execute-stage ALU adder for each add.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    mult_seq_if.slave
//            start/mcand/mplier : request, sampled only in IDLE
//            busy/done/result   : busy in RUN and DONE, one-cycle done pulse,
//                                 result held until the next accepted start
//            alu_*              : ALU operands (acc, shifted mcand) and the
//                                 fixed ADDI control encoding; alu_en marks RUN
//            alu_Out            : combinational ALU sum of alu_A + alu_B
//
// Configuration macro:
//   MULT_EARLY_EXIT_EN - when defined, RUN ends as soon as the remaining
//                        multiplier bits are all zero (result unchanged,
//                        latency becomes data dependent).
module mult_seq (
    input  logic      clk,
    input  logic      rst_n,
    mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] mc_sh_q;
    logic [15:0] mp_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        alu_en_q;

    logic [15:0] acc_d;
    logic        early_exit;

    // Accumulate only when the current multiplier bit is set.
    assign acc_d = mp_q[0] ? bus.alu_Out : acc_q;

`ifdef MULT_EARLY_EXIT_EN
    assign early_exit = (mp_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mc_sh_q  <= '0;
            mp_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            alu_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        acc_q    <= '0;
                        mc_sh_q  <= bus.mcand;
                        mp_q     <= bus.mplier;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        alu_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (early_exit) begin
                        // No remaining multiplier bits: finish without touching the datapath.
                        state_q  <= DONE;
                        alu_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        acc_q   <= acc_d;
                        mc_sh_q <= {mc_sh_q[14:0], 1'b0};
                        mp_q    <= {1'b0, mp_q[15:1]};
                        cnt_q   <= cnt_q + 4'd1;
                        // The 16th add is captured on the same edge that leaves RUN.
                        if (cnt_q == 4'd15) begin
                            state_q  <= DONE;
                            alu_en_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    alu_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.result        = acc_q;
    assign bus.alu_en        = alu_en_q;
    assign bus.alu_A         = acc_q;
    assign bus.alu_B         = mc_sh_q;
    assign bus.alu_Op        = 5'b01000;
    assign bus.alu_invA      = 1'b0;
    assign bus.alu_invB      = 1'b0;
    assign bus.alu_Cin       = 1'b0;
    assign bus.alu_lower_two = 2'b00;

endmodule

// File: doc/mult_seq.md
# mult_seq

Multi-cycle unsigned multiply sequencer for the execute stage. It computes the low 16 bits of a 16x16 product by shift-and-add. The additions reuse the existing ALU adder: the sequencer drives the ALU operand and control inputs with the ADDI encoding and captures the ALU result. Execute-stage muxing hands the ALU inputs to this block whenever `alu_en` is high, and the pipeline stalls on `busy`.

## Interface
Parameters:
- none; width fixed at 16.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `mcand`  in  16  multiplicand, captured on accepted `start`.
- `mplier`  in  16  multiplier, captured on accepted `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  16  product mod 2^16; holds until the next accepted `start`.
- `alu_en`  out  1  high in RUN only; execute-stage ALU input mux selects this block.
- `alu_A`  out  16  accumulator register.
- `alu_B`  out  16  shifted multiplicand register.
- `alu_Op`  out  5  constant 5'b01000 (ADDI: Out = adder sum).
- `alu_invA`, `alu_invB`, `alu_Cin`  out  1 each  constant 0.
- `alu_lower_two`  out  2  constant 2'b00.
- `alu_Out`  in  16  ALU result, combinational from `alu_A` and `alu_B`.

## Operation
- Internal registers:
  - `acc[15:0]`, which drives `result` and `alu_A`.
  - `mc_sh[15:0]`, which drives `alu_B`.
  - `mp[15:0]`.
  - `cnt[3:0]`.
  - `state`: IDLE, RUN or DONE.
- IDLE:
  - `start`=1 → load `acc`=0, `mc_sh`=`mcand`, `mp`=`mplier`, `cnt`=0; go to RUN.
  - `start`=0 → stay in IDLE; all registers hold.
- RUN, on each edge:
  - If `mp[0]`=1, `acc` ← `alu_Out` (`acc`+`mc_sh` mod 2^16); otherwise `acc` holds.
  - `mc_sh` ← `mc_sh`<<1, with zero fill; bits shifted out are discarded.
  - `mp` ← `mp`>>1, with zero fill.
  - `cnt` ← `cnt`+1.
  - When `cnt`=15, go to DONE. The 16th add is captured on the same edge.
- DONE:
  - `done`=1 for exactly one cycle; go to IDLE on the next edge.
- Overflow beyond bit 15 is silently dropped. No flag is produced.
- `start` in RUN or DONE is ignored. It is not queued, and operands are not re-sampled.
- `start` held high continuously: a new operation is accepted in the IDLE cycle following each DONE.

## Timing
- Reset values:
  - state IDLE.
  - `acc`, `mc_sh`, `mp`, `cnt` = 0.
  - `busy`, `done`, `alu_en` = 0.
  - `result` = 0.
  - ALU control outputs at their constants.
- Reset asserted mid-operation: immediate asynchronous return to IDLE, registers cleared, no `done` pulse.
- `busy`, `done` and `alu_en` decode from state registers only; no combinational path from `start`.
- Full-length latency (macro undefined):
  - Edge e0 accepts `start`.
  - RUN spans edges e1..e16.
  - `done` is high in the cycle after e16, i.e. 17 cycles after the accepting cycle.
- Back-to-back operations: minimum interval between accepted `start`s is 18 cycles.
- Single ALU pass per cycle: the path `alu_A`/`alu_B` → adder → `acc` must close in one clock.

## Configuration
- `MULT_EARLY_EXIT_EN` undefined: always 16 RUN cycles; latency is constant.
- `MULT_EARLY_EXIT_EN` defined:
  - In RUN, if `mp`=0 at the edge, go directly to DONE with no register update.
  - Let h = index of the highest set bit of `mplier`. DONE is entered at edge e(h+2).
  - `mplier`=0 enters DONE at e1; `done` is visible after e1.
  - `result` values are identical with or without the macro.

## Test plan
- `mcand`=3, `mplier`=5, macro off → `result`=0x000F with `done` pulse 17 cycles after `start`; `busy` high for 17 cycles.
- 0xFFFF × 0xFFFF → `result`=0x0001 (overflow dropped); 0x1234 × 0x0010 → 0x2340.
- `start` pulsed with new operands during RUN, and again during DONE → ignored; first result unchanged; `done` pulses once.
- `rst_n` low at RUN cycle 8 → `busy`/`alu_en`/`result` = 0 immediately; no `done`; next `start` behaves normally.
- Macro on: `mplier`=0 → `done` after e1, `result`=0; `mplier`=1, `mcand`=7 → `done` after e2, `result`=7; `mplier`=0x8000 → `done` after e17… clipped to e16, `result`=`mcand`<<15.
- `alu_en` high exactly in RUN cycles; `alu_Op`=5'b01000 and other ALU controls 0 throughout.
